// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller:
// FSM state encoding and field-width helpers.
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2,
    IC_DONE = 2'd3
  } ic_state_e;

  // Tag width left over once the line offset and line index are removed
  function automatic int tag_width(input int addr_w, input int line_bytes, input int num_lines);
    return addr_w - $clog2(line_bytes) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_tag_array.sv
// Tag/valid storage for the direct-mapped instruction cache.
// One combinational read port, one write port, single-cycle clear of
// every valid bit. Tags are deliberately left unreset.
module icache_refill_ctrl_tag_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 56
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid
);

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r [NUM_LINES];

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];

  // Valid bits: reset and clear-all win over a line write
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (clear_all) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= wr_valid;
    end
  end

  // Tag storage: written at the end of every completed refill
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction-cache refill controller.
// Zero-cycle hit detection on PC; on a miss, requests the line on the
// memory bus and streams BEATS read beats into the external data array.
// Optional build macro ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter  int ADDR_W     = 64,
  parameter  int LINE_BYTES = 16,
  parameter  int NUM_LINES  = 16,
  parameter  int BUS_W      = 32,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int TAG_W      = tag_width(ADDR_W, LINE_BYTES, NUM_LINES),
  localparam int BEATS      = LINE_BYTES * 8 / BUS_W,
  localparam int BEAT_W     = $clog2(BEATS)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              flush,
  output logic              icache_r,
  output logic              icache_err,
`ifdef ICACHE_PERF_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_index,
  output logic [BEAT_W-1:0] fill_word,
  output logic [BUS_W-1:0]  fill_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_err
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_BYTES - 1);

  ic_state_e         state_r;
  logic [BEAT_W-1:0] beat_r;
  logic              flush_pend_r;
  logic [ADDR_W-1:0] line_addr_r;
  logic              mem_req_r;
  logic              icache_err_r;

  logic [IDX_W-1:0]  pc_idx_s;
  logic [TAG_W-1:0]  pc_tag_s;
  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic              hit_s;
  logic              miss_s;
  logic              err_s;
  logic              last_beat_s;
  logic              to_idle_s;
  logic              clear_all_s;
  logic              wr_valid_s;

  assign pc_idx_s    = PC[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag_s    = PC[ADDR_W-1:OFF_W+IDX_W];
  assign hit_s       = rd_valid_s && (rd_tag_s == pc_tag_s);
  // A flush in IDLE takes the cycle; the miss is re-evaluated afterwards
  assign miss_s      = (state_r == IC_IDLE) && !flush && !hit_s;
  assign err_s       = ((state_r == IC_REQ) || (state_r == IC_FILL)) && mem_err;
  assign last_beat_s = (state_r == IC_FILL) && mem_rvalid && !mem_err && (beat_r == LAST_BEAT);
  assign to_idle_s   = (state_r == IC_DONE) || err_s;
  // Pending flushes are applied on the way back into IDLE
  assign clear_all_s = ((state_r == IC_IDLE) && flush) || (to_idle_s && (flush_pend_r || flush));
  assign wr_valid_s  = !(flush_pend_r || flush);

  assign icache_r    = (state_r == IC_IDLE) && hit_s;
  assign icache_err  = icache_err_r;
  assign fill_we     = (state_r == IC_FILL) && mem_rvalid;
  assign fill_index  = line_addr_r[OFF_W+IDX_W-1:OFF_W];
  assign fill_word   = beat_r;
  assign fill_data   = mem_rdata;
  assign mem_req     = mem_req_r;
  assign mem_addr    = line_addr_r;

  icache_refill_ctrl_tag_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tag_array (
    .clk       (CLK),
    .reset     (reset),
    .clear_all (clear_all_s),
    .rd_idx    (pc_idx_s),
    .rd_valid  (rd_valid_s),
    .rd_tag    (rd_tag_s),
    .wr_en     (last_beat_s),
    .wr_idx    (line_addr_r[OFF_W+IDX_W-1:OFF_W]),
    .wr_tag    (line_addr_r[ADDR_W-1:OFF_W+IDX_W]),
    .wr_valid  (wr_valid_s)
  );

  // Refill sequencer: miss -> request -> beat stream -> one settle cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r      <= IC_IDLE;
      beat_r       <= {BEAT_W{1'b0}};
      flush_pend_r <= 1'b0;
      line_addr_r  <= {ADDR_W{1'b0}};
      mem_req_r    <= 1'b0;
      icache_err_r <= 1'b0;
    end else begin
      icache_err_r <= 1'b0;
      case (state_r)
        IC_IDLE: begin
          flush_pend_r <= 1'b0;
          if (miss_s) begin
            line_addr_r <= PC & ~OFF_MASK;
            mem_req_r   <= 1'b1;
            state_r     <= IC_REQ;
          end
        end
        IC_REQ: begin
          flush_pend_r <= flush_pend_r || flush;
          if (mem_err) begin
            mem_req_r    <= 1'b0;
            icache_err_r <= 1'b1;
            flush_pend_r <= 1'b0;
            state_r      <= IC_IDLE;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            beat_r    <= {BEAT_W{1'b0}};
            state_r   <= IC_FILL;
          end
        end
        IC_FILL: begin
          flush_pend_r <= flush_pend_r || flush;
          if (mem_err) begin
            icache_err_r <= 1'b1;
            flush_pend_r <= 1'b0;
            beat_r       <= {BEAT_W{1'b0}};
            state_r      <= IC_IDLE;
          end else if (mem_rvalid) begin
            if (beat_r == LAST_BEAT) begin
              beat_r  <= {BEAT_W{1'b0}};
              state_r <= IC_DONE;
            end else begin
              beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        IC_DONE: begin
          flush_pend_r <= 1'b0;
          state_r      <= IC_IDLE;
        end
        default: begin
          state_r <= IC_IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Saturating hit and miss counters; flush leaves them untouched
  always_ff @(posedge CLK) begin
    if (reset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (icache_r && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl (LINE_BYTES=16, NUM_LINES=16,
// BUS_W=32, so 4 beats per line). Directed scenarios followed by a
// randomized run against a line-level valid/tag model.
module tb_icache_refill_ctrl;

  logic        CLK;
  logic        reset;
  logic [63:0] PC;
  logic        flush;
  logic        icache_r;
  logic        icache_err;
  logic        fill_we;
  logic [3:0]  fill_index;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which lines hold which tag
  bit          m_valid [16];
  logic [55:0] m_tag   [16];

  icache_refill_ctrl dut (
    .CLK        (CLK),
    .reset      (reset),
    .PC         (PC),
    .flush      (flush),
    .icache_r   (icache_r),
    .icache_err (icache_err),
    .fill_we    (fill_we),
    .fill_index (fill_index),
    .fill_word  (fill_word),
    .fill_data  (fill_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_learn(input logic [63:0] a);
    m_valid[a[7:4]] = 1'b1;
    m_tag[a[7:4]]   = a[63:8];
  endtask

  function automatic bit model_hit(input logic [63:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[63:8]);
  endfunction

  // Entered in the REQ cycle; returns settled in the first IDLE cycle after DONE
  task automatic refill(input logic [63:0] line, input int ack_wait, input bit gaps, input bit a0_data);
    logic [31:0] d;
    int          ngap;
    #1;
    for (int w = 0; w < ack_wait; w++) begin
      chk("req_wait", mem_req, 1'b1);
      chk("req_wait_addr", mem_addr, line);
      tick();
      #1;
    end
    chk("req", mem_req, 1'b1);
    chk("req_addr", mem_addr, line);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ngap = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ngap; g++) begin
        #1;
        chk("gap_we", fill_we, 1'b0);
        tick();
      end
      d          = a0_data ? (32'hA0 + 32'(b)) : $urandom;
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      #1;
      chk("fill_we", fill_we, 1'b1);
      chk("fill_word", fill_word, 64'(b));
      chk("fill_index", fill_index, 64'(line[7:4]));
      chk("fill_data", fill_data, d);
      chk("fill_req_low", mem_req, 1'b0);
      tick();
      mem_rvalid = 1'b0;
    end
    #1;
    chk("done_r", icache_r, 1'b0);
    chk("done_we", fill_we, 1'b0);
    tick();
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] tags [4];
    reset = 1'b1; PC = 64'h0; flush = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    model_clear();
    tick();
    tick();

    // Reset state
    reset = 1'b0;
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", fill_we, 1'b0);
    chk("rst_err", icache_err, 1'b0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_idx", fill_index, 64'h0);
    chk("rst_word", fill_word, 64'h0);

    // Cold miss at PC=0: cycle 0 miss, REQ cycle 1, beats 2..5, hit at 7
    chk("cold_miss", icache_r, 1'b0);
    tick();
    refill(64'h0, 0, 1'b0, 1'b1);
    model_learn(64'h0);
    #1;
    chk("cold_hit_c7", icache_r, 1'b1);

    // Hits in the same line
    PC = 64'h4;
    #1;
    chk("hit_4", icache_r, 1'b1);
    tick();
    chk("hit_4_noreq", mem_req, 1'b0);
    PC = 64'hC;
    #1;
    chk("hit_c", icache_r, 1'b1);
    tick();
    chk("hit_c_noreq", mem_req, 1'b0);

    // Conflict on index 0, then the evicted line misses again
    PC = 64'h100;
    #1;
    chk("conf_miss", icache_r, 1'b0);
    tick();
    refill(64'h100, 1, 1'b0, 1'b0);
    model_learn(64'h100);
    PC = 64'h0;
    #1;
    chk("conf_evicted", icache_r, 1'b0);
    tick();
    refill(64'h0, 0, 1'b0, 1'b0);
    model_learn(64'h0);

    // Flush during the second beat: line completes but stays invalid
    PC = 64'h20;
    #1;
    chk("fl_miss", icache_r, 1'b0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int b = 2; b < 4; b++) begin
      #1;
      chk("fl_we", fill_we, 1'b1);
      chk("fl_word", fill_word, 64'(b));
      tick();
    end
    mem_rvalid = 1'b0;
    model_clear();
    #1;
    chk("fl_done_r", icache_r, 1'b0);
    tick();
    chk("fl_idle_r", icache_r, 1'b0);
    tick();
    refill(64'h20, 0, 1'b0, 1'b0);
    model_learn(64'h20);
    PC = 64'h0;
    #1;
    chk("fl_line0_gone", icache_r, 1'b0);
    tick();
    refill(64'h0, 0, 1'b0, 1'b0);
    model_learn(64'h0);

    // Bus error on beat 1
    PC = 64'h30;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_err = 1'b1;
    tick();
    mem_err = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("err_pulse", icache_err, 1'b1);
    chk("err_r", icache_r, 1'b0);
    chk("err_noreq", mem_req, 1'b0);
    tick();
    chk("err_pulse_end", icache_err, 1'b0);
    refill(64'h30, 0, 1'b0, 1'b0);
    model_learn(64'h30);

    // Reset during the second beat
    PC = 64'h40;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    PC = 64'h4;
    model_clear();
    #1;
    chk("rf_req", mem_req, 1'b0);
    chk("rf_we", fill_we, 1'b0);
    chk("rf_word", fill_word, 64'h0);
    chk("rf_idx", fill_index, 64'h0);
    chk("rf_addr", mem_addr, 64'h0);
    chk("rf_miss", icache_r, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    refill(64'h0, 0, 1'b0, 1'b0);
    model_learn(64'h0);

    // Randomized run against the line model
    tags[0] = 64'h0;
    tags[1] = 64'h100;
    tags[2] = 64'h200;
    tags[3] = 64'hFFFF_0000_0000_0300;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        chk("rnd_flush_noreq", mem_req, 1'b0);
      end else begin
        a = tags[$urandom_range(0, 3)] | (64'($urandom_range(0, 15)) << 4)
            | (64'($urandom_range(0, 3)) << 2);
        PC = a;
        #1;
        chk("rnd_lookup", icache_r, 64'(model_hit(a)));
        if (model_hit(a)) begin
          tick();
          chk("rnd_hit_noreq", mem_req, 1'b0);
        end else begin
          tick();
          PC = {$urandom, $urandom};
          refill(a & ~64'hF, int'($urandom_range(0, 2)), 1'b1, 1'b0);
          model_learn(a);
          PC = a;
          #1;
          chk("rnd_fill_hit", icache_r, 1'b1);
          tick();
          chk("rnd_after_noreq", mem_req, 1'b0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
